// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding and default datapath width for the pipelined logic unit.
package logic_unit_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ADD  = 3'd6,
    OP_SUB  = 3'd7
  } opcode_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational ALU core: eight logic/arithmetic ops with zero and carry/borrow flags.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_e          op,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    // The extra top bit of an unsigned subtract is set exactly when a < b.
    diff  = {1'b0, a} - {1'b0, b};
    q     = '0;
    carry = 1'b0;
    case (op)
      OP_AND:  q = a & b;
      OP_OR:   q = a | b;
      OP_XOR:  q = a ^ b;
      OP_NAND: q = ~(a & b);
      OP_NOR:  q = ~(a | b);
      OP_XNOR: q = ~(a ^ b);
      OP_ADD: begin
        q     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_SUB: begin
        q     = diff[WIDTH-1:0];
        carry = diff[WIDTH];
      end
    endcase
    zero = (q == '0);
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready ALU pipeline with an accumulator that tracks the latest result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       s,
  input  logic             acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             carry
);

  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] x_p1_q, x_p1_d;
  logic [WIDTH-1:0] y_p1_q, y_p1_d;
  opcode_e          op_p1_q, op_p1_d;
  logic             acc_p1_q, acc_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] q_p2_q, q_p2_d;
  logic             zero_p2_q, zero_p2_d;
  logic             carry_p2_q, carry_p2_d;
  logic [WIDTH-1:0] acc_reg_q, acc_reg_d;

  logic             s2_adv, s2_load, accept;
  logic [WIDTH-1:0] opa_p1;
  logic [WIDTH-1:0] core_q;
  logic             core_zero, core_carry;

  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  always_comb begin
    s2_adv   = !vld_p2_q || out_ready;
    in_ready = !vld_p1_q || s2_adv;
    accept   = in_valid && in_ready;
    s2_load  = vld_p1_q && s2_adv;
    opa_p1   = acc_p1_q ? acc_reg_q : x_p1_q;
  end

  always_comb begin
    vld_p1_d   = in_ready ? in_valid : vld_p1_q;
    x_p1_d     = accept ? x : x_p1_q;
    y_p1_d     = accept ? y : y_p1_q;
    op_p1_d    = accept ? opcode_e'(s) : op_p1_q;
    acc_p1_d   = accept ? acc : acc_p1_q;
    vld_p2_d   = s2_adv ? vld_p1_q : vld_p2_q;
    q_p2_d     = s2_load ? core_q : q_p2_q;
    zero_p2_d  = s2_load ? core_zero : zero_p2_q;
    carry_p2_d = s2_load ? core_carry : carry_p2_q;
    acc_reg_d  = s2_load ? core_q : acc_reg_q;
  end

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a     (opa_p1),
    .b     (y_p1_q),
    .op    (op_p1_q),
    .q     (core_q),
    .zero  (core_zero),
    .carry (core_carry)
  );

  // ---- stage 1: operand capture (data needs no reset, qualified by vld_p1) ----
  always_ff @(posedge clk) begin
    x_p1_q   <= x_p1_d;
    y_p1_q   <= y_p1_d;
    op_p1_q  <= op_p1_d;
    acc_p1_q <= acc_p1_d;
  end

  // ---- stage 2: result, flags, accumulator and all valid bits ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      q_p2_q     <= '0;
      zero_p2_q  <= 1'b0;
      carry_p2_q <= 1'b0;
      acc_reg_q  <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      q_p2_q     <= q_p2_d;
      zero_p2_q  <= zero_p2_d;
      carry_p2_q <= carry_p2_d;
      acc_reg_q  <= acc_reg_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign q         = q_p2_q;
  assign zero      = zero_p2_q;
  assign carry     = carry_p2_q;

endmodule
